img_loader: RTL and testbench

Pixel-stream-to-frame-buffer front end for the `ann` classifier. Accepts one 20-bit pixel per valid/ready beat, assembles a full 784-pixel image in an internal register buffer, and presents it on a parallel image bus with a level `img_valid`. Holds that image stable until the consumer acknowledges it. This is the producing end of the `ann` image interface, replacing testbench-driven `img` assignments with a real streaming source.

---
 rtl/ann_pkg.sv | 20 ++
 rtl/img_loader_if.sv | 25 ++
 rtl/img_loader.sv | 113 +++++++++++
 tb/tb_img_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared constants and types for the ann classifier and its image loader.
// The loader state encoding also lives here so both ends agree on it.
package ann_pkg;

    localparam int N_PIX   = 784;
    localparam int PIX_W   = 20;
    localparam int N_CLASS = 10;
    localparam int IDX_W   = $clog2(N_PIX);
    localparam int CNT_W   = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DROP,
        FULL
    } ld_state_e;

endpackage

// File: rtl/img_loader_if.sv
// Pixel stream handshake: one pixel per valid/ready beat.
// master = pixel source, slave = frame loader.
interface img_loader_if;
    import ann_pkg::*;

    logic   pix_valid;
    logic   pix_ready;
    logic   pix_last;
    pixel_t pix_data;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/img_loader.sv
// Streams pixels into a full-frame register buffer for the ann classifier.
// The completed image is held on img with img_valid until img_ack.
module img_loader
    import ann_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    img_loader_if.slave  pix,
    output pixel_t       img [N_PIX],
    output logic         img_valid,
    input  logic         img_ack,
    output logic         frame_err,
    output logic [15:0]  frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIX - 1);

    ld_state_e          state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               wr_en;
    logic               xfer;
    logic               at_end;
    logic [N_PIX-1:0]   we;
    pixel_t             img_q [N_PIX];

    // Handshake outputs come from registered state only.
    assign pix.pix_ready = (state_q == LOAD) || (state_q == DROP);
    assign img_valid     = (state_q == FULL);

    assign xfer   = pix.pix_valid && pix.pix_ready;
    assign at_end = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    wr_en = 1'b1;
                    if (at_end) begin
                        idx_d = '0;
                        if (pix.pix_last) begin
                            state_d = FULL;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (pix.pix_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (xfer && pix.pix_last) begin
                    state_d = LOAD;
                end
            end
            FULL: begin
                if (img_ack) begin
                    state_d = LOAD;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // One-hot write strobe selects the single buffer slot for this beat.
    assign we = wr_en ? ({{(N_PIX-1){1'b0}}, 1'b1} << idx_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PIX; i++) begin
                img_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PIX; i++) begin
                if (we[i]) begin
                    img_q[i] <= pix.pix_data;
                end
            end
        end
    end

    assign img       = img_q;
    assign frame_err = err_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_img_loader.sv
// Directed bench for img_loader: full, gapped, short, long,
// reset-interrupted and counter-wrap frames.
module tb_img_loader;
    import ann_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        img_ack = 1'b0;
    pixel_t      img [N_PIX];
    logic        img_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    img_loader_if bus();

    img_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix       (bus),
        .img       (img),
        .img_valid (img_valid),
        .img_ack   (img_ack),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int     n_chk    = 0;
    int     n_fail   = 0;
    int     xfer_cnt = 0;
    int     err_cyc  = 0;
    int     val_cyc  = 0;
    pixel_t frm [N_PIX];

    always @(posedge clk)
        if (bus.pix_valid && bus.pix_ready) xfer_cnt++;

    always @(negedge clk) begin
        if (frame_err) err_cyc++;
        if (img_valid) val_cyc++;
    end

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic build(int kind);
        for (int i = 0; i < N_PIX; i++) begin
            case (kind)
                0: frm[i] = '0;
                1: frm[i] = pixel_t'(i * 1301 + 7);
                default: frm[i] = pixel_t'((783 - i) * 977);
            endcase
        end
        case (kind)
            0: begin
                frm[152] = 20;
                frm[153] = 252;
                frm[154] = 791;
                frm[238] = 1024;
                frm[659] = 991;
            end
            1: begin
                frm[0]   = 20'hFFFFF;
                frm[783] = 20'h80001;
            end
            default: frm[400] = 20'hFFFFF;
        endcase
    endtask

    // Returns just after the rising edge that completed the transfer.
    task automatic beat(pixel_t d, logic l, int gap);
        int n;
        @(negedge clk);
        if (gap > 0) begin
            bus.pix_valid = 1'b0;
            bus.pix_data  = pixel_t'($urandom);
            repeat (gap) @(negedge clk);
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = d;
        bus.pix_last  = l;
        n = 0;
        while (!bus.pix_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("ready_wait", bus.pix_ready, 1);
        @(posedge clk);
    endtask

    task automatic send(int nbeats, int last_at, int gapmax);
        pixel_t d;
        for (int b = 0; b < nbeats; b++) begin
            d = (b < N_PIX) ? frm[b] : pixel_t'($urandom);
            beat(d, b == last_at, gapmax > 0 ? $urandom_range(0, gapmax) : 0);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic img_cmp(string tag);
        int bad = 0;
        for (int i = 0; i < N_PIX; i++)
            if (img[i] !== frm[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic do_ack(logic [15:0] exp_cnt);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        img_ack = 1'b1;
        @(posedge clk);
        #1;
        check("ack_valid", img_valid, 0);
        check("ack_ready", bus.pix_ready, 1);
        check("ack_cnt", frame_cnt, exp_cnt);
        @(negedge clk);
        img_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int x0, e0, v0;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.pix_data  = '0;

        // reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", bus.pix_ready, 0);
        check("rst_valid", img_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_cnt", frame_cnt, 0);
        check("rst_img", img[152], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_ready", bus.pix_ready, 0);
        @(posedge clk);
        #1 check("load_ready", bus.pix_ready, 1);

        // full frame
        build(0);
        x0 = xfer_cnt;
        send(N_PIX, N_PIX - 1, 0);
        #1;
        check("full_valid", img_valid, 1);
        check("full_ready", bus.pix_ready, 0);
        check("full_p154", img[154], 791);
        check("full_p238", img[238], 1024);
        check("full_xfers", xfer_cnt - x0, N_PIX);
        img_cmp("full_img");
        idle();
        repeat (3) @(negedge clk);
        check("hold_valid", img_valid, 1);
        do_ack(1);

        // gapped stream, then valid held high while FULL
        send(N_PIX, N_PIX - 1, 3);
        #1 check("gap_valid", img_valid, 1);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_last  = 1'b0;
        bus.pix_data  = 20'hABCDE;
        x0 = xfer_cnt;
        repeat (50) @(negedge clk);
        check("full_noxfer", xfer_cnt - x0, 0);
        check("full_stay", img_valid, 1);
        img_cmp("gap_img");
        do_ack(2);

        // short frame
        e0 = err_cyc;
        v0 = val_cyc;
        build(1);
        send(100, 99, 0);
        #1 check("short_err", frame_err, 1);
        idle();
        repeat (5) @(negedge clk);
        check("short_errcyc", err_cyc - e0, 1);
        check("short_novalid", val_cyc - v0, 0);
        check("short_ready", bus.pix_ready, 1);
        send(N_PIX, N_PIX - 1, 0);
        #1 check("after_short_valid", img_valid, 1);
        img_cmp("after_short_img");
        do_ack(3);

        // long frame
        e0 = err_cyc;
        v0 = val_cyc;
        build(2);
        send(N_PIX, -1, 0);
        #1;
        check("long_err", frame_err, 1);
        check("long_drop_ready", bus.pix_ready, 1);
        x0 = xfer_cnt;
        for (int b = 0; b < 6; b++)
            beat(pixel_t'($urandom), b == 5, 0);
        #1;
        check("long_dropped", xfer_cnt - x0, 6);
        check("long_noerr", frame_err, 0);
        idle();
        repeat (2) @(negedge clk);
        check("long_errcyc", err_cyc - e0, 1);
        check("long_novalid", val_cyc - v0, 0);
        build(1);
        send(N_PIX, N_PIX - 1, 0);
        #1 check("after_long_valid", img_valid, 1);
        img_cmp("after_long_img");
        do_ack(4);

        // reset in the middle of a frame
        build(0);
        send(400, -1, 0);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", bus.pix_ready, 0);
        check("mid_rst_valid", img_valid, 0);
        check("mid_rst_cnt", frame_cnt, 0);
        check("mid_rst_img", img[152], 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(N_PIX, N_PIX - 1, 0);
        #1 check("mid_rst_full", img_valid, 1);
        img_cmp("mid_rst_img_all");
        do_ack(1);

        // frame counter wrap
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1 release dut.cnt_q;
        build(2);
        send(N_PIX, N_PIX - 1, 0);
        #1 check("wrap_valid", img_valid, 1);
        check("wrap_pre", frame_cnt, 16'hFFFF);
        do_ack(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
